fft_mag_capture: RTL

- Parametrised successor to the FFT magnitude/RAM-write stage.
- Streams signed complex FFT bins and computes the exact floor magnitude, floor(sqrt(re²+im²)), with an internal pipelined integer square root; no vendor IP.
- Captures bins 0..CAP_LEN-1 of one full frame into the spectrum RAM, tracks the peak bin, then raises wr_done and gates the FFT off.
- Sits between the FFT core output and the spectrum RAM / peak-analysis logic.

---
 rtl/fft_mag_capture.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/fft_mag_capture.sv
// fft_mag_capture: streaming magnitude stage between the FFT core and the
// spectrum RAM. Computes floor(sqrt(re^2 + im^2)) through a fully pipelined
// integer square root (latency DATA_W+2, one sample per clock), writes bins
// 0..CAP_LEN-1 of one frame to RAM, tracks the peak bin, then gates the FFT.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse: abort any capture and re-arm
//   src_real/src_imag     signed complex bin; src_valid/src_sop/src_eop framing
//   fft_en                FFT enable, high while armed or capturing
//   mag_data/mag_valid    magnitude stream (also the RAM write data)
//   mag_eop               src_eop aligned to mag_data
//   wr_en/wr_addr         RAM write strobe and bin address
//   wr_done               sticky capture-complete flag
//   peak_mag/peak_bin     largest captured magnitude and its bin
//   frame_err             sticky: sop arrived before the capture filled
module fft_mag_capture #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BIN_W     = 8,
  parameter int unsigned NFFT      = 256,
  parameter int unsigned CAP_LEN   = 129,
  parameter int unsigned PEAK_SKIP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] src_real,
  input  logic [DATA_W-1:0] src_imag,
  input  logic              src_valid,
  input  logic              src_sop,
  input  logic              src_eop,
  output logic              fft_en,
  output logic [DATA_W-1:0] mag_data,
  output logic              mag_valid,
  output logic              mag_eop,
  output logic              wr_en,
  output logic [BIN_W-1:0]  wr_addr,
  output logic              wr_done,
  output logic [DATA_W-1:0] peak_mag,
  output logic [BIN_W-1:0]  peak_bin,
  output logic              frame_err
);

  localparam int unsigned W       = DATA_W;
  localparam int unsigned SQ_W    = 2 * DATA_W;
  localparam int unsigned REM_W   = DATA_W + 2;
  localparam int unsigned CAP_EFF = (CAP_LEN < NFFT) ? CAP_LEN : NFFT;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(CAP_EFF - 1);
  localparam logic [BIN_W-1:0] SKIP_BIN = BIN_W'(PEAK_SKIP);

  typedef enum logic [1:0] {S_ARM, S_FILL, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [BIN_W-1:0] in_bin;

  // Stage 1 registers: absolute values plus tags
  logic [W-1:0]     re_abs_q, im_abs_q;
  logic             v1_q, e1_q, c1_q;
  logic [BIN_W-1:0] b1_q;

  // Index 0 is the sum-of-squares stage; index k holds k resolved root bits
  logic [SQ_W-1:0]  rad_q  [W+1];
  logic [REM_W-1:0] rem_q  [W+1];
  logic [W-1:0]     root_q [W+1];
  logic             v_q    [W+1];
  logic             e_q    [W+1];
  logic             c_q    [W+1];
  logic [BIN_W-1:0] b_q    [W+1];

  logic [SQ_W-1:0]  rad_n  [W];
  logic [REM_W-1:0] rem_n  [W];
  logic [W-1:0]     root_n [W];

  logic [W-1:0]     re_abs_c, im_abs_c;
  logic [SQ_W-1:0]  sq_c;
  logic             tag_cap_c;
  logic [BIN_W-1:0] tag_bin_c;
  logic             last_out_c;

  // Two's-complement abs; the most negative input maps to 2^(W-1) unsigned
  assign re_abs_c = src_real[W-1] ? (~src_real + W'(1)) : src_real;
  assign im_abs_c = src_imag[W-1] ? (~src_imag + W'(1)) : src_imag;
  assign sq_c     = SQ_W'(re_abs_q) * SQ_W'(re_abs_q) + SQ_W'(im_abs_q) * SQ_W'(im_abs_q);

  // Capture tag for the sample entering the pipeline this cycle
  always_comb begin
    tag_cap_c = 1'b0;
    tag_bin_c = '0;
    if (src_valid && !start) begin
      case (state)
        S_ARM:   tag_cap_c = src_sop;
        S_FILL: begin
          tag_cap_c = 1'b1;
          tag_bin_c = src_sop ? '0 : in_bin;
        end
        default: ;
      endcase
    end
  end

  assign last_out_c = wr_en && (wr_addr == LAST_BIN);

  // Restoring square root: each stage brings down two radicand bits
  always_comb begin : sqrt_comb
    logic [REM_W-1:0] rem_sh;
    logic [REM_W-1:0] trial;
    rem_sh = '0;
    trial  = '0;
    for (int k = 0; k < W; k++) begin
      rem_sh   = REM_W'({rem_q[k], rad_q[k][SQ_W-1 -: 2]});
      trial    = {root_q[k], 2'b01};
      rad_n[k] = rad_q[k] << 2;
      if (rem_sh >= trial) begin
        rem_n[k]  = rem_sh - trial;
        root_n[k] = {root_q[k][W-2:0], 1'b1};
      end else begin
        rem_n[k]  = rem_sh;
        root_n[k] = {root_q[k][W-2:0], 1'b0};
      end
    end
  end

  // Data and tag pipeline; start kills every in-flight capture tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_abs_q <= '0;
      im_abs_q <= '0;
      v1_q     <= 1'b0;
      e1_q     <= 1'b0;
      c1_q     <= 1'b0;
      b1_q     <= '0;
      for (int k = 0; k <= W; k++) begin
        rad_q[k]  <= '0;
        rem_q[k]  <= '0;
        root_q[k] <= '0;
        v_q[k]    <= 1'b0;
        e_q[k]    <= 1'b0;
        c_q[k]    <= 1'b0;
        b_q[k]    <= '0;
      end
    end else begin
      re_abs_q  <= re_abs_c;
      im_abs_q  <= im_abs_c;
      v1_q      <= src_valid;
      e1_q      <= src_valid & src_eop;
      c1_q      <= tag_cap_c;
      b1_q      <= tag_bin_c;
      rad_q[0]  <= sq_c;
      rem_q[0]  <= '0;
      root_q[0] <= '0;
      v_q[0]    <= v1_q;
      e_q[0]    <= e1_q;
      c_q[0]    <= c1_q & ~start;
      b_q[0]    <= b1_q;
      for (int k = 0; k < W; k++) begin
        rad_q[k+1]  <= rad_n[k];
        rem_q[k+1]  <= rem_n[k];
        root_q[k+1] <= root_n[k];
        v_q[k+1]    <= v_q[k];
        e_q[k+1]    <= e_q[k];
        c_q[k+1]    <= c_q[k] & ~start;
        b_q[k+1]    <= b_q[k];
      end
    end
  end

  assign mag_data  = root_q[W];
  assign mag_valid = v_q[W];
  assign mag_eop   = e_q[W];
  assign wr_en     = c_q[W];
  assign wr_addr   = b_q[W];

  // Input-side capture FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ARM;
      in_bin    <= '0;
      fft_en    <= 1'b1;
      wr_done   <= 1'b0;
      frame_err <= 1'b0;
    end else if (start) begin
      state     <= S_ARM;
      in_bin    <= '0;
      fft_en    <= 1'b1;
      wr_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        S_ARM, S_FILL: begin
          if (tag_cap_c) begin
            if (state == S_FILL && src_sop) frame_err <= 1'b1;
            if (tag_bin_c == LAST_BIN) begin
              state <= S_DRAIN;
            end else begin
              state  <= S_FILL;
              in_bin <= tag_bin_c + BIN_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (last_out_c) begin
            state   <= S_DONE;
            wr_done <= 1'b1;
            fft_en  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Peak search over written bins; strict compare keeps the lowest tied bin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_mag <= '0;
      peak_bin <= '0;
    end else if (start) begin
      peak_mag <= '0;
      peak_bin <= '0;
    end else if (wr_en) begin
      if (wr_addr == '0) begin
        peak_mag <= '0;
        peak_bin <= '0;
      end else if (wr_addr >= SKIP_BIN && mag_data > peak_mag) begin
        peak_mag <= mag_data;
        peak_bin <= wr_addr;
      end
    end
  end

endmodule
